core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
Instruction sequencer for the GPU core array. It holds a small program memory of 16-bit core opcodes, loaded by the host. When started, it steps through the program and broadcasts `opcode` with `execute` to all cores. Sequencer-only control opcodes (loop set, conditional jump, halt) are consumed internally and never reach the cores. A cycle budget aborts programs that overrun the per-pixel time slot.

Parameters:
PROG_DEPTH, 32, number of 16-bit program words (power of two, 2..256)
ADDR_WIDTH, $clog2(PROG_DEPTH), program counter / memory address width
MAX_CYCLES, 64, maximum RUN cycles per program before forced abort (≥1)
CNT_WIDTH, $clog2(MAX_CYCLES+1), width of the run-cycle counter

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle request to run the program from address 0
prog_we  input  1  program memory write strobe
prog_addr  input  ADDR_WIDTH  program write address
prog_wdata  input  16  program write data
opcode  output  16  opcode broadcast to cores
execute  output  1  opcode valid for cores this cycle
busy  output  1  program running
done  output  1  one-cycle pulse at program end (halt or abort)
overrun  output  1  sticky: last program aborted by budget; cleared on next accepted start
pc  output  ADDR_WIDTH  current program counter (debug)

Behaviour:
- Reset (sync, rst=1 at a clk edge) values: state IDLE; opcode=0, execute=0, busy=0, done=0, overrun=0, pc=0, loop_cnt=0, cycle_cnt=0. Program memory is not cleared. Reset mid-run aborts immediately; no done pulse.
- Program memory: PROG_DEPTH x 16, synchronous write. A write takes effect when prog_we=1 and busy=0. Writes while busy=1 are dropped. Read is combinational at pc.
- Control opcodes: instr[15:14]=2'b11 and instr[8]=0. Selected by instr[13:12]:
  - 00 HALT: end the program.
  - 01 LSET: loop_cnt <= instr[7:0].
  - 10 JNZ: if loop_cnt≠0, then loop_cnt <= loop_cnt-1 and pc <= instr[ADDR_WIDTH-1:0]; else pc <= pc+1.
  - 11 NOP: pc+1.
  - All other words are core opcodes, including the store form 11 with instr[8]=1.
- State IDLE:
  - busy=0, execute=0.
  - start=1: pc<=0, cycle_cnt<=0, overrun<=0, busy<=1, go to RUN.
- State RUN, one instruction per clock:
  - Core opcode: opcode<=instr, execute<=1, pc<=pc+1.
  - Control opcode: execute<=0, opcode holds its previous value, pc as defined above.
  - HALT: execute<=0, busy<=0, done<=1 for one cycle, go to IDLE. pc keeps the HALT address.
  - cycle_cnt increments every RUN cycle. When cycle_cnt = MAX_CYCLES-1 and the current word is not HALT, the word is not issued: execute<=0, overrun<=1, done<=1, busy<=0, go to IDLE.
- Latency: instruction at address k (reached with no prior control words) appears on opcode/execute k+1 cycles after the start cycle. Address 0 is registered in the first RUN cycle and visible the cycle after it.
- execute is high for exactly one cycle per issued core opcode. The opcode value is stable while execute=1.
- pc wraps modulo PROG_DEPTH: pc+1 from PROG_DEPTH-1 gives 0. A program without HALT is terminated only by the budget.
- start while busy=1 is ignored. start in the same cycle as the done pulse (already IDLE next cycle) is not accepted. It is accepted the cycle after.
- loop_cnt is 8 bits and persists across programs until the next LSET or rst.
- done and busy are never high in the same cycle.

Test Plan:
- Load [0x0005 (load r0=5), 0x4000, 0xC000 HALT], pulse start → execute high 2 consecutive cycles with opcode 0x0005 then 0x4000; done pulses once; busy falls; overrun=0.
- Loop: [0xD003 LSET 3, 0x8000 shl, 0xE001 JNZ→1, 0xC000] → 0x8000 issued exactly 4 times; execute never high for 0xD003/0xE001; done after 10 RUN cycles.
- Budget: MAX_CYCLES=8, program [0x8000, 0xE000 JNZ→0 with LSET 255 first] → done with overrun=1 after 8 RUN cycles; next start clears overrun.
- Store vs. control: word 0xC103 (store) → issued to cores with execute=1; word 0xC003 → treated as HALT.
- prog_we during RUN to address 1 with 0xFFFF → memory unchanged (re-run shows original word); start during RUN is ignored.
- rst asserted in middle of loop → next cycle execute=0, busy=0, pc=0, no done pulse; program memory contents intact on rerun.

Source files
------------

// File: rtl/core_sequencer.sv
// Instruction sequencer: steps a host-loaded program and broadcasts core opcodes,
// consuming loop/jump/halt words internally and aborting runs that exceed a cycle budget.
module core_sequencer #(
  parameter int PROG_DEPTH = 32,
  parameter int ADDR_WIDTH = $clog2(PROG_DEPTH),
  parameter int MAX_CYCLES = 64,
  parameter int CNT_WIDTH  = $clog2(MAX_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [15:0]           prog_wdata,
  output logic [15:0]           opcode,
  output logic                  execute,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic [ADDR_WIDTH-1:0] pc
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [15:0]           prog_mem [PROG_DEPTH];
  logic [0:0]            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next, pc_inc;
  logic [15:0]           opcode_reg, opcode_next;
  logic                  execute_reg, execute_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  overrun_reg, overrun_next;
  logic [7:0]            loop_reg, loop_next;
  logic [CNT_WIDTH-1:0]  cycle_reg, cycle_next;

  logic [15:0] instr;
  logic        is_ctrl;
  logic        is_halt;
  logic        budget_hit;

  // The program image is frozen while a run is in progress.
  always_ff @(posedge clk) begin
    if (prog_we && !busy_reg) begin
      prog_mem[prog_addr] <= prog_wdata;
    end
  end

  assign instr      = prog_mem[pc_reg];
  assign is_ctrl    = (instr[15:14] == 2'b11) && !instr[8];
  assign is_halt    = is_ctrl && (instr[13:12] == 2'b00);
  assign budget_hit = (cycle_reg == CNT_WIDTH'(MAX_CYCLES - 1));
  assign pc_inc     = pc_reg + 1'b1;

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    opcode_next  = opcode_reg;
    execute_next = 1'b0;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    overrun_next = overrun_reg;
    loop_next    = loop_reg;
    cycle_next   = cycle_reg;
    case (state_reg)
      ST_IDLE: begin
        // A start coinciding with the done pulse is deliberately ignored.
        if (start && !done_reg) begin
          pc_next      = '0;
          cycle_next   = '0;
          overrun_next = 1'b0;
          busy_next    = 1'b1;
          state_next   = ST_RUN;
        end
      end
      default: begin
        cycle_next = cycle_reg + 1'b1;
        if (is_halt) begin
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end else if (budget_hit) begin
          overrun_next = 1'b1;
          busy_next    = 1'b0;
          done_next    = 1'b1;
          state_next   = ST_IDLE;
        end else if (!is_ctrl) begin
          opcode_next  = instr;
          execute_next = 1'b1;
          pc_next      = pc_inc;
        end else begin
          case (instr[13:12])
            2'b01: begin
              loop_next = instr[7:0];
              pc_next   = pc_inc;
            end
            2'b10: begin
              if (loop_reg != 8'd0) begin
                loop_next = loop_reg - 8'd1;
                pc_next   = instr[ADDR_WIDTH-1:0];
              end else begin
                pc_next = pc_inc;
              end
            end
            default: pc_next = pc_inc;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      pc_reg      <= '0;
      opcode_reg  <= '0;
      execute_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      overrun_reg <= 1'b0;
      loop_reg    <= '0;
      cycle_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      opcode_reg  <= opcode_next;
      execute_reg <= execute_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      overrun_reg <= overrun_next;
      loop_reg    <= loop_next;
      cycle_reg   <= cycle_next;
    end
  end

  assign opcode  = opcode_reg;
  assign execute = execute_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign overrun = overrun_reg;
  assign pc      = pc_reg;

endmodule

// File: tb/tb_core_sequencer.sv
// Drives two sequencers (budgets 64 and 8) with shared stimulus and compares each
// against a program-level interpreter of the opcode rules.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, prog_we;
  logic [4:0]  prog_addr;
  logic [15:0] prog_wdata;
  logic [15:0] op   [2];
  logic [4:0]  pcv  [2];
  logic [1:0]  exe, bsy, dn, ovr;

  int n_checks = 0;
  int n_fails  = 0;

  logic [15:0] mem_m   [32];
  logic [15:0] exp_ops [2][64];
  int          exp_n   [2];
  int          exp_cyc [2];
  int          exp_pc  [2];
  logic        exp_ovr [2];
  logic [7:0]  lc_m    [2];
  logic [15:0] last_m  [2];
  int          max_c   [2];

  always #5 clk = ~clk;

  core_sequencer #(.PROG_DEPTH(32), .MAX_CYCLES(64)) dut_a (
    .clk(clk), .rst(rst), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .opcode(op[0]), .execute(exe[0]), .busy(bsy[0]),
    .done(dn[0]), .overrun(ovr[0]), .pc(pcv[0]));

  core_sequencer #(.PROG_DEPTH(32), .MAX_CYCLES(8)) dut_b (
    .clk(clk), .rst(rst), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .opcode(op[1]), .execute(exe[1]), .busy(bsy[1]),
    .done(dn[1]), .overrun(ovr[1]), .pc(pcv[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Interprets the program image directly: which core words go out, how many
  // run cycles it takes, and where it ends up.
  task automatic model(input int d);
    int p = 0;
    int n = 0;
    logic [15:0] w;
    logic ctrl;
    exp_n[d]   = 0;
    exp_ovr[d] = 1'b0;
    while (1) begin
      w    = mem_m[p];
      ctrl = (w[15:14] == 2'b11) && !w[8];
      if (ctrl && w[13:12] == 2'b00) break;
      if (n == max_c[d] - 1) begin
        exp_ovr[d] = 1'b1;
        break;
      end
      if (!ctrl) begin
        exp_ops[d][exp_n[d]] = w;
        exp_n[d]++;
        last_m[d] = w;
        p = (p + 1) % 32;
      end else if (w[13:12] == 2'b01) begin
        lc_m[d] = w[7:0];
        p = (p + 1) % 32;
      end else if (w[13:12] == 2'b10 && lc_m[d] != 0) begin
        lc_m[d] = lc_m[d] - 8'd1;
        p = int'(w[4:0]);
      end else begin
        p = (p + 1) % 32;
      end
      n++;
    end
    exp_cyc[d] = n + 1;
    exp_pc[d]  = p;
  endtask

  task automatic load(input logic [15:0] img [32]);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      prog_we    = 1'b1;
      prog_addr  = 5'(i);
      prog_wdata = img[i];
      mem_m[i]   = img[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic run_prog(input int id);
    int  got_n [2];
    bit  fin   [2];
    int  cyc;
    for (int d = 0; d < 2; d++) begin
      model(d);
      got_n[d] = 0;
      fin[d]   = 1'b0;
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check("overrun_cleared", 32'(ovr[d]), 32'd0);
    end
    cyc = 0;
    while (!(fin[0] && fin[1]) && cyc < 150) begin
      @(posedge clk);
      #1;
      cyc++;
      start   = 1'b0;
      prog_we = 1'b0;
      for (int d = 0; d < 2; d++) begin
        check("busy_and_done", 32'(bsy[d] & dn[d]), 32'd0);
        if (fin[d]) begin
          check("quiet_after_done", 32'(exe[d]), 32'd0);
        end else begin
          if (exe[d]) begin
            if (got_n[d] < exp_n[d]) check("issued_opcode", 32'(op[d]), 32'(exp_ops[d][got_n[d]]));
            else check("extra_issue", 32'd1, 32'd0);
            got_n[d]++;
          end
          if (dn[d]) begin
            fin[d] = 1'b1;
            check("run_cycles", 32'(cyc), 32'(exp_cyc[d]));
            check("issue_count", 32'(got_n[d]), 32'(exp_n[d]));
            check("overrun", 32'(ovr[d]), 32'(exp_ovr[d]));
            check("end_pc", 32'(pcv[d]), 32'(exp_pc[d]));
            check("held_opcode", 32'(op[d]), 32'(last_m[d]));
            check("busy_low", 32'(bsy[d]), 32'd0);
          end
        end
      end
      // Writes and starts during a run must have no effect.
      if (bsy[0] && bsy[1]) begin
        if (cyc == 1 || $urandom_range(0, 3) == 0) begin
          prog_we    = 1'b1;
          prog_addr  = (cyc == 1) ? 5'd1 : 5'($urandom_range(0, 31));
          prog_wdata = (cyc == 1) ? 16'hFFFF : 16'($urandom);
        end
        if ($urandom_range(0, 5) == 0) start = 1'b1;
      end
    end
    start   = 1'b0;
    prog_we = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if (!fin[d]) check("done_timeout", 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("done_one_cycle", 32'(dn[d]), 32'd0);
    end
    $display("run %0d: a issued %0d cycles %0d ovr %0d | b issued %0d cycles %0d ovr %0d",
             id, got_n[0], exp_cyc[0], exp_ovr[0], got_n[1], exp_cyc[1], exp_ovr[1]);
  endtask

  task automatic fill(output logic [15:0] img [32], input logic [15:0] w0, input logic [15:0] w1,
                      input logic [15:0] w2, input logic [15:0] w3);
    for (int i = 0; i < 32; i++) img[i] = 16'hC000;
    img[0] = w0;
    img[1] = w1;
    img[2] = w2;
    img[3] = w3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      lc_m[d]   = 8'd0;
      last_m[d] = 16'd0;
    end
  endtask

  initial begin
    logic [15:0] img [32];
    logic [15:0] w;
    int          wait_n;
    rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    max_c[0] = 64;
    max_c[1] = 8;
    do_reset();
    for (int d = 0; d < 2; d++) begin
      check("rst_opcode", 32'(op[d]), 32'd0);
      check("rst_execute", 32'(exe[d]), 32'd0);
      check("rst_busy", 32'(bsy[d]), 32'd0);
      check("rst_done", 32'(dn[d]), 32'd0);
      check("rst_overrun", 32'(ovr[d]), 32'd0);
      check("rst_pc", 32'(pcv[d]), 32'd0);
    end

    fill(img, 16'h0005, 16'h4000, 16'hC000, 16'hC000);
    load(img);
    run_prog(0);
    fill(img, 16'hD003, 16'h8000, 16'hE001, 16'hC000);
    load(img);
    run_prog(1);
    fill(img, 16'hD0FF, 16'h8000, 16'hE001, 16'hC000);
    load(img);
    run_prog(2);
    fill(img, 16'hC103, 16'hC003, 16'h1234, 16'hC000);
    load(img);
    run_prog(3);
    run_prog(4);

    // Reset in the middle of a loop, then rerun the intact image.
    fill(img, 16'hD003, 16'h8000, 16'hE001, 16'hC000);
    load(img);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("midrst_execute", 32'(exe[d]), 32'd0);
      check("midrst_busy", 32'(bsy[d]), 32'd0);
      check("midrst_pc", 32'(pcv[d]), 32'd0);
      check("midrst_done", 32'(dn[d]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      lc_m[d]   = 8'd0;
      last_m[d] = 16'd0;
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) check("midrst_no_done", 32'(dn[d]), 32'd0);
    run_prog(5);

    // Start held through the done cycle is only taken one cycle later.
    fill(img, 16'hC000, 16'hC000, 16'hC000, 16'hC000);
    load(img);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_n = 0;
    while (!dn[0] && wait_n < 10) begin
      @(posedge clk);
      #1;
      wait_n++;
    end
    check("halt0_done_seen", 32'(dn[0]), 32'd1);
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) check("start_on_done_ignored", 32'(bsy[d]), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int d = 0; d < 2; d++) check("start_after_done_taken", 32'(bsy[d]), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) check("halt0_idle", 32'(bsy[d]), 32'd0);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 32; i++) begin
        case ($urandom_range(0, 9))
          4: w = 16'hD000 | 16'($urandom_range(0, 3));
          5: w = 16'hE000 | 16'($urandom_range(0, 31));
          6: w = 16'hF000 | 16'($urandom_range(0, 255));
          7: w = 16'hC000 | 16'(16'($urandom_range(0, 7)) << 9);
          default: begin
            w = 16'($urandom);
            if (w[15:14] == 2'b11) w[8] = 1'b1;
          end
        endcase
        img[i] = w;
      end
      load(img);
      run_prog(10 + r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
